// File: rtl/spike_rate_decoder.sv
// Spike-train rate decoder: counts spikes over a programmable window of enabled
// cycles and presents the count on a valid/ready channel. Optional min-ISI via SPIKE_DECODER_ISI_EN.
module spike_rate_decoder #(
  parameter int WINDOW_BITS = 8,
  parameter int COUNT_BITS  = 8,
  parameter int ISI_BITS    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   spike_in,
  input  logic [WINDOW_BITS-1:0] window_len,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_BITS-1:0]  out_count,
  output logic                   out_sat,
  output logic [ISI_BITS-1:0]    out_isi_min,
  output logic                   overrun
);

  localparam logic [WINDOW_BITS-1:0] ONE_W = 1;
  localparam logic [COUNT_BITS-1:0]  ONE_C = 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                 state;
  logic [WINDOW_BITS-1:0] win_cnt;
  logic [WINDOW_BITS-1:0] len_shadow;
  logic [WINDOW_BITS-1:0] len_eff;
  logic [WINDOW_BITS-1:0] term;
  logic                   fresh;
  logic [COUNT_BITS-1:0]  acc;
  logic [COUNT_BITS-1:0]  acc_next;
  logic                   acc_max;
  logic                   sat;
  logic                   sat_next;
  logic                   win_end;
  logic [ISI_BITS-1:0]    min_next;

  // On the first cycle of a window the shadow is not yet loaded, so use the live input.
  assign len_eff  = fresh ? window_len : len_shadow;
  assign term     = len_eff - ONE_W;
  assign win_end  = enable && (win_cnt == term);
  assign acc_max  = &acc;
  assign acc_next = (spike_in && !acc_max) ? acc + ONE_C : acc;
  assign sat_next = sat | (spike_in & acc_max);

`ifdef SPIKE_DECODER_ISI_EN
  logic [ISI_BITS-1:0] isi_cnt;
  logic [ISI_BITS-1:0] min_isi;
  logic                seen;

  always_comb begin
    min_next = min_isi;
    if (spike_in && seen && (isi_cnt < min_isi))
      min_next = isi_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isi_cnt <= '0;
      min_isi <= '1;
      seen    <= 1'b0;
    end else if (clear) begin
      isi_cnt <= '0;
      min_isi <= '1;
      seen    <= 1'b0;
    end else if (enable) begin
      if (win_end) begin
        isi_cnt <= '0;
        min_isi <= '1;
        seen    <= 1'b0;
      end else begin
        min_isi <= min_next;
        if (spike_in) begin
          isi_cnt <= {{(ISI_BITS-1){1'b0}}, 1'b1};
          seen    <= 1'b1;
        end else if (!(&isi_cnt)) begin
          isi_cnt <= isi_cnt + {{(ISI_BITS-1){1'b0}}, 1'b1};
        end
      end
    end
  end
`else
  assign min_next = '1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt    <= '0;
      len_shadow <= '0;
      fresh      <= 1'b1;
      acc        <= '0;
      sat        <= 1'b0;
    end else if (clear) begin
      win_cnt    <= '0;
      fresh      <= 1'b1;
      acc        <= '0;
      sat        <= 1'b0;
    end else begin
      if (fresh) begin
        len_shadow <= window_len;
        fresh      <= 1'b0;
      end
      if (enable) begin
        if (win_end) begin
          win_cnt <= '0;
          acc     <= '0;
          sat     <= 1'b0;
          fresh   <= 1'b1;
        end else begin
          win_cnt <= win_cnt + ONE_W;
          acc     <= acc_next;
          sat     <= sat_next;
        end
      end
    end
  end

  // Output holding register; the oldest unaccepted result wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      out_valid   <= 1'b0;
      out_count   <= '0;
      out_sat     <= 1'b0;
      out_isi_min <= '1;
      overrun     <= 1'b0;
    end else if (clear) begin
      state       <= EMPTY;
      out_valid   <= 1'b0;
      out_count   <= '0;
      out_sat     <= 1'b0;
      out_isi_min <= '1;
      overrun     <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (win_end) begin
            state       <= FULL;
            out_valid   <= 1'b1;
            out_count   <= acc_next;
            out_sat     <= sat_next;
            out_isi_min <= min_next;
          end
        end
        FULL: begin
          if (out_ready) begin
            if (win_end) begin
              out_count   <= acc_next;
              out_sat     <= sat_next;
              out_isi_min <= min_next;
            end else begin
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
          end else if (win_end) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
